// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus signals between the ICache, LSB, mem_ctrl and the byte-wide RAM/IO bus.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ic_to_mc_request;
  logic [ADDR_WIDTH-1:0] ic_to_mc_pc;
  logic                  mc_to_ic_ready;
  logic [31:0]           mc_to_ic_inst;

  logic                  lsb_to_mc_request;
  logic                  lsb_to_mc_wr;
  logic [1:0]            lsb_to_mc_size;
  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr;
  logic [31:0]           lsb_to_mc_data;
  logic                  mc_to_lsb_ready;
  logic [31:0]           mc_to_lsb_data;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  ic_to_mc_request, ic_to_mc_pc,
    output mc_to_ic_ready, mc_to_ic_inst,
    input  lsb_to_mc_request, lsb_to_mc_wr, lsb_to_mc_size, lsb_to_mc_addr, lsb_to_mc_data,
    output mc_to_lsb_ready, mc_to_lsb_data,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output ic_to_mc_request, ic_to_mc_pc,
    input  mc_to_ic_ready, mc_to_ic_inst,
    output lsb_to_mc_request, lsb_to_mc_wr, lsb_to_mc_size, lsb_to_mc_addr, lsb_to_mc_data,
    input  mc_to_lsb_ready, mc_to_lsb_data,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves LSB (priority) and ICache accesses as 1/2/4 consecutive
// byte transfers; read ready at E(n+1), write ready at E(n) plus IO stalls, one-cycle ready pulses.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      rollback_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_state;
  logic                  r_src_lsb, w_src_lsb;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [2:0]            r_len, w_len;
  logic [31:0]           r_wdata, w_wdata;
  logic [31:0]           r_rbuf, w_rbuf;
  logic [2:0]            r_issue_idx, w_issue_idx;
  logic [2:0]            r_recv_idx, w_recv_idx;
  logic                  r_cap_en, w_cap_en;
  logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a;
  logic [7:0]            r_mem_dout, w_mem_dout;
  logic                  r_mem_wr, w_mem_wr;
  logic                  r_ic_ready, w_ic_ready;
  logic                  r_lsb_ready, w_lsb_ready;
  logic [31:0]           r_ic_inst, w_ic_inst;
  logic [31:0]           r_lsb_data, w_lsb_data;

  logic                  w_req_any;
  logic                  w_req_wr;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [2:0]            w_req_len;
  logic [ADDR_WIDTH-1:0] w_byte_addr;
  logic [7:0]            w_wr_byte;
  logic [31:0]           w_asm;

  always_comb begin
    w_state     = r_state;
    w_src_lsb   = r_src_lsb;
    w_addr      = r_addr;
    w_len       = r_len;
    w_wdata     = r_wdata;
    w_rbuf      = r_rbuf;
    w_issue_idx = r_issue_idx;
    w_recv_idx  = r_recv_idx;
    w_cap_en    = r_cap_en;
    w_mem_a     = r_mem_a;
    w_mem_dout  = r_mem_dout;
    w_mem_wr    = 1'b0;
    w_ic_ready  = 1'b0;
    w_lsb_ready = 1'b0;
    w_ic_inst   = r_ic_inst;
    w_lsb_data  = r_lsb_data;

    w_req_any  = bus.lsb_to_mc_request | bus.ic_to_mc_request;
    w_req_wr   = bus.lsb_to_mc_request & bus.lsb_to_mc_wr;
    w_req_addr = bus.lsb_to_mc_request ? bus.lsb_to_mc_addr : bus.ic_to_mc_pc;
    w_req_len  = 3'd4;
    if (bus.lsb_to_mc_request) begin
      case (bus.lsb_to_mc_size)
        2'd0:    w_req_len = 3'd1;
        2'd1:    w_req_len = 3'd2;
        default: w_req_len = 3'd4;
      endcase
    end
    w_byte_addr = r_addr + ADDR_WIDTH'(r_issue_idx);
    case (r_issue_idx[1:0])
      2'd0:    w_wr_byte = r_wdata[7:0];
      2'd1:    w_wr_byte = r_wdata[15:8];
      2'd2:    w_wr_byte = r_wdata[23:16];
      default: w_wr_byte = r_wdata[31:24];
    endcase
    w_asm = r_rbuf | (32'(bus.mem_din) << {r_recv_idx[1:0], 3'b000});

    case (r_state)
      S_IDLE: begin
        if (w_req_any && !rollback_in) begin
          w_src_lsb  = bus.lsb_to_mc_request;
          w_addr     = w_req_addr;
          w_len      = w_req_len;
          w_wdata    = bus.lsb_to_mc_data;
          w_rbuf     = 32'd0;
          w_recv_idx = 3'd0;
          w_cap_en   = 1'b0;
          w_mem_a    = w_req_addr;
          if (w_req_wr) begin
            w_state = S_WRITE;
            // A store into the IO window waits here while the IO buffer is full.
            if (bus.io_buffer_full && w_req_addr[17:16] == 2'b11) begin
              w_issue_idx = 3'd0;
            end else begin
              w_mem_dout  = bus.lsb_to_mc_data[7:0];
              w_mem_wr    = 1'b1;
              w_issue_idx = 3'd1;
            end
          end else begin
            w_state     = S_READ;
            w_issue_idx = 3'd1;
          end
        end
      end
      S_READ: begin
        if (rollback_in || (!r_src_lsb && !bus.ic_to_mc_request)) begin
          w_state     = S_IDLE;
          w_issue_idx = 3'd0;
          w_recv_idx  = 3'd0;
        end else begin
          if (r_issue_idx < r_len) begin
            w_mem_a     = w_byte_addr;
            w_issue_idx = r_issue_idx + 3'd1;
          end
          // RAM data trails the address by two edges; capture starts on the second READ edge.
          w_cap_en = 1'b1;
          if (r_cap_en) begin
            w_rbuf     = w_asm;
            w_recv_idx = r_recv_idx + 3'd1;
            if (r_recv_idx == r_len - 3'd1) begin
              w_state = S_DONE;
              if (r_src_lsb) begin
                w_lsb_ready = 1'b1;
                w_lsb_data  = w_asm;
              end else begin
                w_ic_ready = 1'b1;
                w_ic_inst  = w_asm;
              end
            end
          end
        end
      end
      S_WRITE: begin
        if (r_issue_idx == r_len) begin
          w_state     = S_DONE;
          w_lsb_ready = 1'b1;
        end else if (!(bus.io_buffer_full && w_byte_addr[17:16] == 2'b11)) begin
          w_mem_a     = w_byte_addr;
          w_mem_dout  = w_wr_byte;
          w_mem_wr    = 1'b1;
          w_issue_idx = r_issue_idx + 3'd1;
        end
      end
      default: begin
        w_state     = S_IDLE;
        w_issue_idx = 3'd0;
        w_recv_idx  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_src_lsb   <= 1'b0;
      r_addr      <= '0;
      r_len       <= 3'd0;
      r_wdata     <= 32'd0;
      r_rbuf      <= 32'd0;
      r_issue_idx <= 3'd0;
      r_recv_idx  <= 3'd0;
      r_cap_en    <= 1'b0;
      r_mem_a     <= '0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
      r_ic_ready  <= 1'b0;
      r_lsb_ready <= 1'b0;
      r_ic_inst   <= 32'd0;
      r_lsb_data  <= 32'd0;
    end else if (rdy_in) begin
      r_state     <= w_state;
      r_src_lsb   <= w_src_lsb;
      r_addr      <= w_addr;
      r_len       <= w_len;
      r_wdata     <= w_wdata;
      r_rbuf      <= w_rbuf;
      r_issue_idx <= w_issue_idx;
      r_recv_idx  <= w_recv_idx;
      r_cap_en    <= w_cap_en;
      r_mem_a     <= w_mem_a;
      r_mem_dout  <= w_mem_dout;
      r_mem_wr    <= w_mem_wr;
      r_ic_ready  <= w_ic_ready;
      r_lsb_ready <= w_lsb_ready;
      r_ic_inst   <= w_ic_inst;
      r_lsb_data  <= w_lsb_data;
    end
  end

  assign bus.mem_a          = r_mem_a;
  assign bus.mem_dout       = r_mem_dout;
  assign bus.mem_wr         = r_mem_wr;
  assign bus.mc_to_ic_ready = r_ic_ready;
  assign bus.mc_to_ic_inst  = r_ic_inst;
  assign bus.mc_to_lsb_ready = r_lsb_ready;
  assign bus.mc_to_lsb_data = r_lsb_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, vector table, corner-case sequences and a random run
// checked against a transaction-level memory model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic rollback;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .rdy_in      (rdy),
    .rollback_in (rollback),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM: samples mem_a each edge, data visible one cycle later; backdoor port for preloading.
  logic [7:0]  ram [logic [31:0]];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = 32'd0;
  logic [7:0]  bd_dat = 8'd0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (ram.exists(bus.mem_a)) bus.mem_din <= ram[bus.mem_a];
    else                       bus.mem_din <= dflt(bus.mem_a);
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    if (bd_we)      ram[bd_addr] = bd_dat;
  end

  // Reference model: flat byte memory plus per-access latency rules.
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_rd(a + 32'(k))) << (8 * k));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'(d >> (8 * k));
  endtask

  function automatic int n_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr = a; bd_dat = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic drive_lsb(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.lsb_to_mc_request = 1'b1;
    bus.lsb_to_mc_wr = wr; bus.lsb_to_mc_size = sz;
    bus.lsb_to_mc_addr = a; bus.lsb_to_mc_data = d;
  endtask

  // One complete access; counts edges from the accepting edge E0 to the ready pulse.
  task automatic run_req(input string nm, input bit ic, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_d);
    int  e;
    bit  got, other;
    @(negedge clk);
    if (ic) begin
      bus.ic_to_mc_request = 1'b1; bus.ic_to_mc_pc = a;
    end else begin
      drive_lsb(wr, sz, a, wd);
    end
    e = -1; got = 1'b0; other = 1'b0;
    while (!got && e < 40) begin
      @(posedge clk); #1; e++;
      if (ic ? bus.mc_to_ic_ready : bus.mc_to_lsb_ready) got = 1'b1;
      if (ic ? bus.mc_to_lsb_ready : bus.mc_to_ic_ready) other = 1'b1;
    end
    bus.ic_to_mc_request = 1'b0;
    bus.lsb_to_mc_request = 1'b0;
    check({nm, " ready seen"}, 32'(got), 32'd1);
    check({nm, " latency"}, 32'(e), 32'(exp_lat));
    check({nm, " other ready"}, 32'(other), 32'd0);
    if (!wr) check({nm, " data"}, ic ? bus.mc_to_ic_inst : bus.mc_to_lsb_data, exp_d);
    @(posedge clk); #1;
    check({nm, " pulse width"}, 32'(bus.mc_to_ic_ready | bus.mc_to_lsb_ready), 32'd0);
    if (wr) ref_store(a, n_of(sz), wd);
  endtask

  typedef struct {
    bit          ic;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input bit ic, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input int lat, input logic [31:0] d);
    vec_t v;
    v.ic = ic; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = wd; v.lat = lat; v.data = d;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e;
    bit          got, seen;
    logic [31:0] w;

    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
    bus.ic_to_mc_request = 1'b0; bus.ic_to_mc_pc = 32'd0;
    bus.lsb_to_mc_request = 1'b0; bus.lsb_to_mc_wr = 1'b0; bus.lsb_to_mc_size = 2'd0;
    bus.lsb_to_mc_addr = 32'd0; bus.lsb_to_mc_data = 32'd0;
    bus.io_buffer_full = 1'b0;

    poke(32'h104, 8'h13); poke(32'h105, 8'h05); poke(32'h106, 8'h10); poke(32'h107, 8'h00);
    poke(32'h202, 8'hFF); poke(32'h203, 8'h80);

    // Reset held with both requesters active.
    @(negedge clk);
    bus.ic_to_mc_request = 1'b1; bus.ic_to_mc_pc = 32'h104;
    drive_lsb(1'b0, 2'd1, 32'h202, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("reset strobes", {29'd0, bus.mem_wr, bus.mc_to_ic_ready, bus.mc_to_lsb_ready}, 32'd0);
      check("reset mem_a", bus.mem_a, 32'd0);
      check("reset data", bus.mc_to_ic_inst | bus.mc_to_lsb_data | 32'(bus.mem_dout), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = -1; got = 1'b0;
    while (!got && e < 30) begin
      @(posedge clk); #1; e++;
      if (bus.mc_to_lsb_ready) got = 1'b1;
    end
    bus.lsb_to_mc_request = 1'b0;
    check("arb lsb first ready", 32'(got), 32'd1);
    check("arb lsb latency", 32'(e), 32'd3);
    check("arb lsb data", bus.mc_to_lsb_data, 32'h000080FF);
    check("arb ic not yet", 32'(bus.mc_to_ic_ready), 32'd0);
    got = 1'b0;
    while (!got && e < 40) begin
      @(posedge clk); #1; e++;
      if (bus.mc_to_ic_ready) got = 1'b1;
    end
    bus.ic_to_mc_request = 1'b0;
    check("arb ic ready edge", 32'(e), 32'd10);
    check("arb ic data", bus.mc_to_ic_inst, 32'h00100513);
    @(posedge clk); #1;
    check("arb ic pulse width", 32'(bus.mc_to_ic_ready), 32'd0);

    // ICache fetch byte address sequence.
    @(negedge clk);
    bus.ic_to_mc_request = 1'b1; bus.ic_to_mc_pc = 32'h104;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("fetch mem_a", bus.mem_a, 32'h104 + 32'(k));
      check("fetch mem_wr", 32'(bus.mem_wr), 32'd0);
    end
    @(posedge clk); #1;
    check("fetch ready before E5", 32'(bus.mc_to_ic_ready), 32'd0);
    @(posedge clk); #1;
    check("fetch ready E5", 32'(bus.mc_to_ic_ready), 32'd1);
    check("fetch inst", bus.mc_to_ic_inst, 32'h00100513);
    bus.ic_to_mc_request = 1'b0;
    @(posedge clk); #1;
    check("fetch pulse width", 32'(bus.mc_to_ic_ready), 32'd0);

    // Word store byte trace.
    @(negedge clk);
    drive_lsb(1'b1, 2'd2, 32'h400, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      w = 32'hDEADBEEF >> (8 * k);
      check("store mem_wr", 32'(bus.mem_wr), 32'd1);
      check("store mem_a", bus.mem_a, 32'h400 + 32'(k));
      check("store mem_dout", 32'(bus.mem_dout), 32'(w[7:0]));
    end
    @(posedge clk); #1;
    check("store ready E4", 32'(bus.mc_to_lsb_ready), 32'd1);
    check("store wr dropped", 32'(bus.mem_wr), 32'd0);
    bus.lsb_to_mc_request = 1'b0;
    @(posedge clk); #1;
    check("store pulse width", 32'(bus.mc_to_lsb_ready), 32'd0);
    ref_store(32'h400, 4, 32'hDEADBEEF);

    // Vector table.
    tbl.push_back(mkv(1, 0, 2'd2, 32'h104, 0, 5, 32'h00100513));
    tbl.push_back(mkv(0, 0, 2'd1, 32'h202, 0, 3, 32'h000080FF));
    tbl.push_back(mkv(0, 1, 2'd2, 32'h440, 32'hCAFEF00D, 4, 0));
    tbl.push_back(mkv(0, 0, 2'd2, 32'h440, 0, 5, 32'hCAFEF00D));
    tbl.push_back(mkv(0, 0, 2'd2, 32'h400, 0, 5, 32'hDEADBEEF));
    tbl.push_back(mkv(0, 0, 2'd0, 32'h401, 0, 2, 32'h000000BE));
    tbl.push_back(mkv(0, 0, 2'd3, 32'h400, 0, 5, 32'hDEADBEEF));
    tbl.push_back(mkv(1, 0, 2'd2, 32'h400, 0, 5, 32'hDEADBEEF));
    tbl.push_back(mkv(0, 1, 2'd1, 32'h500, 32'h1234ABCD, 2, 0));
    tbl.push_back(mkv(0, 0, 2'd2, 32'h500, 0, 5, 32'hA3A2ABCD));
    tbl.push_back(mkv(0, 1, 2'd0, 32'h502, 32'hFFFFFF77, 1, 0));
    tbl.push_back(mkv(0, 0, 2'd1, 32'h502, 0, 3, 32'h0000A377));
    tbl.push_back(mkv(0, 0, 2'd1, 32'h403, 0, 3, 32'h0000A5DE));
    for (int i = 0; i < tbl.size(); i++)
      run_req($sformatf("vec%0d", i), tbl[i].ic, tbl[i].wr, tbl[i].sz, tbl[i].addr,
              tbl[i].wdata, tbl[i].lat, tbl[i].data);

    // IO stall on a byte store into the IO window.
    @(negedge clk);
    bus.io_buffer_full = 1'b1;
    drive_lsb(1'b1, 2'd0, 32'h00030000, 32'h0000005C);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("io stall mem_wr", {30'd0, bus.mem_wr, bus.mc_to_lsb_ready}, 32'd0);
    end
    bus.io_buffer_full = 1'b0;
    @(posedge clk); #1;
    check("io write issued", 32'(bus.mem_wr), 32'd1);
    check("io write addr", bus.mem_a, 32'h00030000);
    check("io write byte", 32'(bus.mem_dout), 32'h5C);
    @(posedge clk); #1;
    check("io ready", 32'(bus.mc_to_lsb_ready), 32'd1);
    bus.lsb_to_mc_request = 1'b0;
    @(posedge clk); #1;
    ref_store(32'h00030000, 1, 32'h5C);

    // Rollback at E2 of a held fetch: aborted, then re-accepted at E3.
    @(negedge clk);
    bus.ic_to_mc_request = 1'b1; bus.ic_to_mc_pc = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rollback = 1'b1;
    @(posedge clk); #1;
    rollback = 1'b0;
    e = 2; got = 1'b0;
    while (!got && e < 30) begin
      @(posedge clk); #1; e++;
      if (bus.mc_to_ic_ready) got = 1'b1;
    end
    bus.ic_to_mc_request = 1'b0;
    check("rollback refetch ready", 32'(got), 32'd1);
    check("rollback refetch edge", 32'(e), 32'd8);
    check("rollback refetch data", bus.mc_to_ic_inst, 32'hDEADBEEF);
    @(posedge clk); #1;

    // ICache request withdrawn mid-read.
    @(negedge clk);
    bus.ic_to_mc_request = 1'b1; bus.ic_to_mc_pc = 32'h104;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.ic_to_mc_request = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.mc_to_ic_ready) seen = 1'b1;
    end
    check("withdrawn fetch no ready", 32'(seen), 32'd0);
    run_req("after withdraw", 0, 0, 2'd0, 32'h401, 0, 2, 32'h000000BE);

    // Rollback during a store does not abort it.
    @(negedge clk);
    drive_lsb(1'b1, 2'd2, 32'h700, 32'h0BADCAFE);
    e = -1; got = 1'b0;
    while (!got && e < 30) begin
      @(posedge clk); #1; e++;
      rollback = (e < 4);
      if (bus.mc_to_lsb_ready) got = 1'b1;
    end
    rollback = 1'b0;
    bus.lsb_to_mc_request = 1'b0;
    check("rollback store ready edge", 32'(e), 32'd4);
    @(posedge clk); #1;
    ref_store(32'h700, 4, 32'h0BADCAFE);
    run_req("store survived rollback", 0, 0, 2'd2, 32'h700, 0, 5, 32'h0BADCAFE);

    // Rollback in IDLE delays acceptance by one edge.
    @(negedge clk);
    rollback = 1'b1;
    drive_lsb(1'b0, 2'd0, 32'h401, 32'd0);
    @(posedge clk); #1;
    rollback = 1'b0;
    e = 0; got = 1'b0;
    while (!got && e < 30) begin
      @(posedge clk); #1; e++;
      if (bus.mc_to_lsb_ready) got = 1'b1;
    end
    bus.lsb_to_mc_request = 1'b0;
    check("idle rollback ready edge", 32'(e), 32'd3);
    check("idle rollback data", bus.mc_to_lsb_data, 32'h000000BE);
    @(posedge clk); #1;

    // Random accesses against the reference model.
    for (int i = 0; i < 80; i++) begin
      bit          ic, wr;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      int          n;
      ic = ($urandom_range(0, 3) == 0);
      wr = !ic && ($urandom_range(0, 1) == 1);
      sz = 2'($urandom_range(0, 3));
      a  = 32'h800 + 32'($urandom_range(0, 63));
      if (ic) a = a & ~32'd3;
      wd = $urandom;
      n  = ic ? 4 : n_of(sz);
      run_req($sformatf("rand%0d", i), ic, wr, sz, a, wd, wr ? n : n + 1,
              wr ? 32'd0 : ref_load(a, n));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
